bit_vault_rf: RTL and testbench

Parametrised successor to the 4x8 register vault. It provides a DATA_W x DEPTH register file with one write port and two registered read ports. Each entry has a sticky write-lock bit, and a background clear sequencer zeroes every unlocked entry. It sits beside the datapath as scratch/config storage; locked entries hold constants that must survive software clears.

---
 rtl/bit_vault_rf_if.sv | 30 +++
 rtl/bit_vault_rf.sv | 78 +++++++
 tb/tb_bit_vault_rf.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bit_vault_rf_if.sv
// Write, lock, clear and dual-read signals of the bit_vault_rf register file.
// The master drives requests and addresses. The slave returns status and read data.
interface bit_vault_rf_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic              we;
    logic              lock;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic              clr_start;
    logic              busy;
    logic              wr_err;
    logic [AW-1:0]     raddr0;
    logic [AW-1:0]     raddr1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output we, lock, waddr, wdata, clr_start, raddr0, raddr1,
        input  busy, wr_err, rdata0, rdata1
    );

    modport slave (
        input  we, lock, waddr, wdata, clr_start, raddr0, raddr1,
        output busy, wr_err, rdata0, rdata1
    );
endinterface

// File: rtl/bit_vault_rf.sv
// DATA_W x DEPTH register file: one write port, two registered read ports, sticky per-entry locks,
// and a background clear of unlocked entries. Define BIT_VAULT_RF_BYPASS_EN for write-to-read forwarding.
module bit_vault_rf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bit_vault_rf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [AW-1:0]     ptr;
    logic [DEPTH-1:0]  locked;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              clr_hit;

    // When DEPTH is not a power of two, some address codes name no entry.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    assign wr_ok   = bus.we && in_range(bus.waddr) && !locked[bus.waddr] && (state == IDLE);
    assign clr_hit = (state == CLEAR) && !locked[ptr];
    assign bus.busy = (state == CLEAR);

    function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] a);
        if (!in_range(a)) return '0;
`ifdef BIT_VAULT_RF_BYPASS_EN
        if (wr_ok && bus.waddr == a) return bus.wdata;
        if (clr_hit && ptr == a) return '0;
`endif
        return mem[a];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            locked     <= '0;
            bus.wr_err <= 1'b0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
            // NOTE: the storage is reset on purpose. Software relies on every entry reading 0 after rst_n.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            bus.wr_err <= bus.we && !wr_ok;
            bus.rdata0 <= read_port(bus.raddr0);
            bus.rdata1 <= read_port(bus.raddr1);

            if (bus.lock && in_range(bus.waddr)) locked[bus.waddr] <= 1'b1;
            if (wr_ok) mem[bus.waddr] <= bus.wdata;
            if (clr_hit) mem[ptr] <= '0;

            case (state)
                IDLE: begin
                    if (bus.clr_start) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_vault_rf.sv
// Directed bench for bit_vault_rf. It uses one 4x8 instance and one 5x16 instance for the out-of-range address codes.
module tb_bit_vault_rf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    bit_vault_rf_if #(.DATA_W(8),  .DEPTH(4)) bus_a ();
    bit_vault_rf_if #(.DATA_W(16), .DEPTH(5)) bus_b ();

    bit_vault_rf #(.DATA_W(8),  .DEPTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    bit_vault_rf #(.DATA_W(16), .DEPTH(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct {
        logic       we;
        logic       lock;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic [1:0] ra0;
        logic [1:0] ra1;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       eerr;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

`ifdef BIT_VAULT_RF_BYPASS_EN
    localparam logic [7:0] BYP_EXP = 8'h5A;
`else
    localparam logic [7:0] BYP_EXP = 8'h00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic we, input logic lock, input logic [1:0] wa, input logic [7:0] wd,
                          input logic [1:0] r0, input logic [1:0] r1, input logic cs);
        bus_a.we = we; bus_a.lock = lock; bus_a.waddr = wa; bus_a.wdata = wd;
        bus_a.raddr0 = r0; bus_a.raddr1 = r1; bus_a.clr_start = cs;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                          input logic [2:0] r0, input logic [2:0] r1);
        bus_b.we = we; bus_b.lock = 1'b0; bus_b.waddr = wa; bus_b.wdata = wd;
        bus_b.raddr0 = r0; bus_b.raddr1 = r1; bus_b.clr_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cycles;

        vecs[0]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 8'hA5, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd1, 8'h3C, 2'd0, 2'd2, 8'hA5, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 8'hFF, 2'd1, 2'd3, 8'h3C, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 8'h01, 2'd0, 2'd1, 8'hA5, 8'h3C, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'hFF, 8'h01, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd1, 8'h77, 2'd0, 2'd2, 8'hA5, 8'hFF, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 8'h77, 8'h77, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 8'h99, 2'd3, 2'd0, 8'h01, 8'hA5, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 8'h77, 8'h01, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'd3, 8'h00, 2'd3, 2'd2, 8'h01, 8'hFF, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 2'd3, 8'h55, 2'd3, 2'd1, 8'h01, 8'h77, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 8'h01, 8'hA5, 1'b0};

        bus_a.we = 0; bus_a.lock = 0; bus_a.waddr = 0; bus_a.wdata = 0;
        bus_a.raddr0 = 0; bus_a.raddr1 = 0; bus_a.clr_start = 0;
        bus_b.we = 0; bus_b.lock = 0; bus_b.waddr = 0; bus_b.wdata = 0;
        bus_b.raddr0 = 0; bus_b.raddr1 = 0; bus_b.clr_start = 0;

        // Reset values while rst_n is held low.
        #12;
        check("reset busy", 32'(bus_a.busy), 0);
        check("reset wr_err", 32'(bus_a.wr_err), 0);
        check("reset rdata0", 32'(bus_a.rdata0), 0);
        check("reset rdata1", 32'(bus_a.rdata1), 0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            step_a(vecs[i].we, vecs[i].lock, vecs[i].waddr, vecs[i].wdata, vecs[i].ra0, vecs[i].ra1, 1'b0);
            check($sformatf("vec%0d rdata0", i), 32'(bus_a.rdata0), 32'(vecs[i].e0));
            check($sformatf("vec%0d rdata1", i), 32'(bus_a.rdata1), 32'(vecs[i].e1));
            check($sformatf("vec%0d wr_err", i), 32'(bus_a.wr_err), 32'(vecs[i].eerr));
        end

        // Background clear with entry 2 locked. A write and a restart are attempted mid-clear.
        do_reset();
        step_a(1, 0, 2'd0, 8'h10, 0, 0, 0);
        step_a(1, 0, 2'd1, 8'h20, 0, 0, 0);
        step_a(1, 1, 2'd2, 8'h30, 0, 0, 0);
        step_a(1, 0, 2'd3, 8'h40, 0, 0, 0);
        check("clr busy before start", 32'(bus_a.busy), 0);
        step_a(0, 0, 2'd0, 8'h00, 0, 0, 1);
        check("clr busy rises", 32'(bus_a.busy), 1);
        busy_cycles = 1;
        step_a(1, 0, 2'd0, 8'hEE, 0, 0, 1);
        check("clr write rejected wr_err", 32'(bus_a.wr_err), 1);
        if (bus_a.busy) busy_cycles++;
        for (int k = 0; k < 10 && bus_a.busy; k++) begin
            step_a(0, 0, 2'd0, 8'h00, 0, 0, 0);
            if (k == 0) check("clr wr_err one cycle", 32'(bus_a.wr_err), 0);
            if (bus_a.busy) busy_cycles++;
        end
        check("clr busy length", 32'(busy_cycles), 4);
        step_a(0, 0, 2'd0, 8'h00, 2'd0, 2'd1, 0);
        check("clr entry0", 32'(bus_a.rdata0), 0);
        check("clr entry1", 32'(bus_a.rdata1), 0);
        step_a(0, 0, 2'd0, 8'h00, 2'd2, 2'd3, 0);
        check("clr entry2 locked", 32'(bus_a.rdata0), 32'h30);
        check("clr entry3", 32'(bus_a.rdata1), 0);

        // Asynchronous reset during a clear.
        step_a(0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 1);
        step_a(0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 0);
        rst_n = 1'b0;
        #1;
        check("midclr busy", 32'(bus_a.busy), 0);
        check("midclr rdata0", 32'(bus_a.rdata0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step_a(0, 0, 2'd0, 8'h00, 2'd0, 2'd1, 0);
        check("post-reset entry0", 32'(bus_a.rdata0), 0);
        check("post-reset entry1", 32'(bus_a.rdata1), 0);
        step_a(0, 0, 2'd0, 8'h00, 2'd2, 2'd3, 0);
        check("post-reset entry2", 32'(bus_a.rdata0), 0);
        check("post-reset entry3", 32'(bus_a.rdata1), 0);
        step_a(1, 0, 2'd2, 8'h11, 2'd0, 2'd0, 0);
        check("post-reset lock cleared wr_err", 32'(bus_a.wr_err), 0);
        step_a(0, 0, 2'd0, 8'h00, 2'd2, 2'd2, 0);
        check("post-reset lock cleared data", 32'(bus_a.rdata0), 32'h11);

        // Write and read the same address on the same edge.
        step_a(1, 0, 2'd0, 8'h5A, 2'd0, 2'd0, 0);
        check("same-edge rdata0", 32'(bus_a.rdata0), 32'(BYP_EXP));
        step_a(0, 0, 2'd0, 8'h00, 2'd0, 2'd0, 0);
        check("next-edge rdata0", 32'(bus_a.rdata0), 32'h5A);

        // DEPTH=5 instance: out-of-range address codes.
        for (int i = 0; i < 5; i++) step_b(1, 3'(i), 16'h1000 + 16'(i), 0, 0);
        step_b(1, 3'd6, 16'hBEEF, 3'd7, 3'd4);
        check("b oob write wr_err", 32'(bus_b.wr_err), 1);
        check("b oob read rdata0", 32'(bus_b.rdata0), 0);
        check("b last entry", 32'(bus_b.rdata1), 32'h1004);
        for (int i = 0; i < 5; i += 2) begin
            step_b(0, 3'd0, 16'h0, 3'(i), 3'((i + 1) % 5));
            if (i == 0) check("b wr_err one cycle", 32'(bus_b.wr_err), 0);
            check($sformatf("b entry%0d", i), 32'(bus_b.rdata0), 32'h1000 + 32'(i));
            check($sformatf("b entry%0d", (i + 1) % 5), 32'(bus_b.rdata1), 32'h1000 + 32'((i + 1) % 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
